// File: rtl/psum_scatter_ctrl.sv
// Frame sequencer for the 12x12 partial-sum array: clear sweep, round-robin product
// writes onto a single coordinate port, then a raster-order drain of all 144 entries.
module psum_scatter_ctrl #(
  parameter int NREQ = 4,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_x,
  input  logic [4*NREQ-1:0]    req_y,
  input  logic [DW*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [3:0]           x_cor,
  output logic [3:0]           y_cor,
  output logic [DW-1:0]        out_data,
  output logic                 out_we,
  output logic                 out_clr,
  output logic                 out_rd,
  output logic                 busy,
  output logic                 done,
  output logic                 coord_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            gnt_ok;
  logic [3:0]      gnt_x;
  logic [3:0]      gnt_y;
  logic [DW-1:0]   gnt_data;
  logic            flush_lat;
  logic [3:0]      cnt_x;
  logic [3:0]      cnt_y;
  logic [3:0]      nxt_x;
  logic [3:0]      nxt_y;
  logic            cnt_last;
  int              idx;

  assign cnt_last = (cnt_x == 4'd11) && (cnt_y == 4'd11);
  assign nxt_x    = (cnt_x == 4'd11) ? 4'd0 : cnt_x + 4'd1;
  assign nxt_y    = (cnt_x == 4'd11) ? cnt_y + 4'd1 : cnt_y;
  assign busy     = (state != IDLE);

  // Walk downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (state == ACCUM && !flush) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_x    = req_x[int'(gnt_idx)*4 +: 4];
  assign gnt_y    = req_y[int'(gnt_idx)*4 +: 4];
  assign gnt_data = req_data[int'(gnt_idx)*DW +: DW];
  assign gnt_ok   = (gnt_x < 4'd12) && (gnt_y < 4'd12);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   if (cnt_last) state_nxt = (flush_lat || flush) ? DRAIN : ACCUM;
      ACCUM:   if (flush) state_nxt = DRAIN;
      DRAIN:   if (out_rd && cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      cnt_x     <= '0;
      cnt_y     <= '0;
      flush_lat <= 1'b0;
      x_cor     <= '0;
      y_cor     <= '0;
      out_data  <= '0;
      out_we    <= 1'b0;
      out_clr   <= 1'b0;
      out_rd    <= 1'b0;
      done      <= 1'b0;
      coord_err <= 1'b0;
    end else begin
      out_we  <= 1'b0;
      out_clr <= 1'b0;
      out_rd  <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt_x     <= '0;
            cnt_y     <= '0;
            x_cor     <= '0;
            y_cor     <= '0;
            out_clr   <= 1'b1;
            coord_err <= 1'b0;
            flush_lat <= 1'b0;
          end
        end
        CLEAR: begin
          if (flush) flush_lat <= 1'b1;
          if (!cnt_last) begin
            cnt_x   <= nxt_x;
            cnt_y   <= nxt_y;
            x_cor   <= nxt_x;
            y_cor   <= nxt_y;
            out_clr <= 1'b1;
          end else begin
            cnt_x <= '0;
            cnt_y <= '0;
          end
        end
        ACCUM: begin
          if (gnt_any) begin
            rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
            if (gnt_ok) begin
              out_we   <= 1'b1;
              x_cor    <= gnt_x;
              y_cor    <= gnt_y;
              out_data <= gnt_data;
            end else begin
              coord_err <= 1'b1;
            end
          end
          if (flush) begin
            cnt_x <= '0;
            cnt_y <= '0;
          end
        end
        DRAIN: begin
          // First DRAIN cycle is a bubble so a trailing write never abuts a read.
          if (!out_rd) begin
            out_rd <= 1'b1;
            x_cor  <= cnt_x;
            y_cor  <= cnt_y;
          end else if (!cnt_last) begin
            cnt_x  <= nxt_x;
            cnt_y  <= nxt_y;
            x_cor  <= nxt_x;
            y_cor  <= nxt_y;
            out_rd <= 1'b1;
          end else begin
            cnt_x <= '0;
            cnt_y <= '0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
